mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide: CLK  input  1  system clock, rising-edge.
REQ-002 SHALL provide: RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: iREN  input  1  instruction fetch request.
REQ-004 SHALL provide: iaddr  input  32  fetch word address.
REQ-005 SHALL provide: dREN  input  1  data read request.
REQ-006 SHALL provide: dWEN  input  1  data write request.
REQ-007 SHALL provide: daddr  input  32  data word address.
REQ-008 SHALL provide: dstore  input  32  write data.
REQ-009 SHALL provide: ram_ready  input  1  RAM completes the current access this cycle.
REQ-010 SHALL provide: ram_load  input  32  RAM read data.
REQ-011 SHALL provide: ram_ren, ram_wen  output  1 each  RAM read and write strobes.
REQ-012 SHALL provide: ram_addr, ram_store  output  32 each  RAM address and write data.
REQ-013 SHALL provide: ihit, dhit  output  1 each  access complete, one pulse per access.
REQ-014 SHALL provide: iload, dload  output  32 each  read data returned to the requester.
REQ-015 SHALL provide: timeout_err  output  1  one-cycle pulse when an access is aborted by the watchdog.

Function
REQ-016 SHALL implement FSM states IDLE, IACC and DACC, with a registered last_grant bit (0 = instruction, 1 = data).
REQ-017 IDLE: all RAM strobes 0, ram_addr and ram_store 0, all hits 0.
REQ-018 IDLE transitions: data request only (dREN|dWEN) -> DACC; iREN only -> IACC; none -> IDLE.
REQ-019 Both pending in IDLE -> DACC if last_grant = 0, else IACC; last_grant updates on each grant.
REQ-020 IACC: ram_ren = 1; ram_addr = iaddr.
REQ-021 DACC with dWEN = 1: ram_wen = 1, ram_ren = 0, ram_addr = daddr, ram_store = dstore; dWEN wins over dREN.
REQ-022 DACC with dWEN = 0: ram_ren = 1, ram_addr = daddr.
REQ-023 Hit is combinational: ihit/dhit = 1 in the cycle in which ram_ready = 1 in IACC/DACC; iload/dload = ram_load in that cycle, else 0.
REQ-024 On ram_ready the FSM SHALL return to IDLE; IDLE lasts at least one cycle between accesses, so minimum latency from request to hit is 2 cycles.
REQ-025 Requester drops its request in IACC/DACC before ram_ready -> abort to IDLE next cycle; no hit issued; strobes continue to follow the live inputs until then.
REQ-026 Requesters SHALL hold address and data stable while their request is high; the arbiter does not latch them.
REQ-027 ihit and dhit SHALL never be high in the same cycle.

Reset
REQ-028 RST high SHALL asynchronously force state = IDLE and last_grant = 0, clear the watchdog counter, and drive every output to 0, including mid-access.
REQ-029 The first edge after RST deasserts SHALL evaluate REQ-018/019 normally.

Configuration
REQ-030 Macro MEM_ARBITER_TIMEOUT_EN SHALL select the watchdog.
REQ-031 Defined: an 8-bit counter clears on entry to IACC/DACC and increments on each cycle in IACC/DACC without ram_ready. On the 255th such cycle, the FSM aborts to IDLE, pulses timeout_err for that cycle, and issues no hit.
REQ-032 Not defined: no counter is built; timeout_err is tied to 0; accesses wait indefinitely for ram_ready.

Verification
REQ-033 iREN = 1, iaddr = 0x40, ram_ready = 1 in IACC with ram_load = 0x3C01_0001 -> ram_ren = 1 and ram_addr = 0x40 in cycle 1; ihit = 1 and iload = 0x3C01_0001 in cycle 1; IDLE in cycle 2.
REQ-034 iREN = dREN = 1 held continuously, RAM always ready, after reset -> grant order D, I, D, I; hits alternate dhit/ihit every 2 cycles.
REQ-035 dWEN = dREN = 1, daddr = 0x100, dstore = 0xDEAD_BEEF -> ram_wen = 1, ram_ren = 0, ram_store = 0xDEAD_BEEF, dhit = 1 on ram_ready.
REQ-036 dREN drops in DACC before ram_ready -> IDLE next cycle, dhit stays 0; RST pulsed during IACC -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 MEM_ARBITER_TIMEOUT_EN defined, iREN = 1, ram_ready held 0 -> timeout_err pulses once after 255 cycles in IACC, ihit = 0, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester/RAM bus for mem_arbiter. The slave modport is the arbiter's view;
// master is the view of the requesters and RAM model driving it.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ram_ready;
  logic [31:0] ram_load;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        timeout_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    output ram_ren, ram_wen, ram_addr, ram_store, ihit, dhit, iload, dload, timeout_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    input  ram_ren, ram_wen, ram_addr, ram_store, ihit, dhit, iload, dload, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port RAM arbiter with alternating priority.
// Define MEM_ARBITER_TIMEOUT_EN to build the 255-cycle access watchdog.
module mem_arbiter (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        dreq;
  logic        wdog_expired;
  logic        ren, wen, ihit, dhit, terr;
  logic [31:0] addr, store, iload, dload;

  assign dreq = bus.dREN | bus.dWEN;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Held at zero in IDLE, so every access starts counting from zero.
  always_comb begin
    wdog_d = '0;
    if ((state_q == IACC || state_q == DACC) && !bus.ram_ready)
      wdog_d = wdog_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign wdog_expired = (wdog_q == 8'd254);
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ren          = 1'b0;
    wen          = 1'b0;
    addr         = '0;
    store        = '0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    iload        = '0;
    dload        = '0;
    terr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && (!bus.iREN || !last_grant_q)) begin
          state_d      = DACC;
          last_grant_d = 1'b1;
        end else if (bus.iREN) begin
          state_d      = IACC;
          last_grant_d = 1'b0;
        end
      end
      IACC: begin
        ren  = bus.iREN;
        addr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ram_ready) begin
          ihit    = 1'b1;
          iload   = bus.ram_load;
          state_d = IDLE;
        end else if (wdog_expired) begin
          terr    = 1'b1;
          state_d = IDLE;
        end
      end
      DACC: begin
        // Write takes precedence when both data strobes are high.
        wen   = bus.dWEN;
        ren   = bus.dREN & ~bus.dWEN;
        addr  = bus.daddr;
        store = bus.dWEN ? bus.dstore : '0;
        if (!dreq) begin
          state_d = IDLE;
        end else if (bus.ram_ready) begin
          dhit    = 1'b1;
          dload   = bus.ram_load;
          state_d = IDLE;
        end else if (wdog_expired) begin
          terr    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.ram_ren     = ren;
  assign bus.ram_wen     = wen;
  assign bus.ram_addr    = addr;
  assign bus.ram_store   = store;
  assign bus.ihit        = ihit;
  assign bus.dhit        = dhit;
  assign bus.iload       = iload;
  assign bus.dload       = dload;
  assign bus.timeout_err = terr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus multi-cycle corner sequences.
// Watchdog expectations follow MEM_ARBITER_TIMEOUT_EN.
module tb_mem_arbiter;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        terr;
  } out_t;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        rdy;
    logic [31:0] load;
    out_t        exp;
  } vec_t;

  localparam out_t Z = '0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic out_t sample();
    out_t o;
    o.ren   = bus.ram_ren;
    o.wen   = bus.ram_wen;
    o.addr  = bus.ram_addr;
    o.store = bus.ram_store;
    o.ihit  = bus.ihit;
    o.dhit  = bus.dhit;
    o.iload = bus.iload;
    o.dload = bus.dload;
    o.terr  = bus.timeout_err;
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h ihit=%b dhit=%b iload=%h dload=%h terr=%b, want ren=%b wen=%b addr=%h store=%h ihit=%b dhit=%b iload=%h dload=%h terr=%b",
               name, act.ren, act.wen, act.addr, act.store, act.ihit, act.dhit, act.iload, act.dload, act.terr,
               exp.ren, exp.wen, exp.addr, exp.store, exp.ihit, exp.dhit, exp.iload, exp.dload, exp.terr);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iren, input logic [31:0] iaddr, input logic dren, input logic dwen,
                       input logic [31:0] daddr, input logic [31:0] dstore, input logic rdy,
                       input logic [31:0] load);
    bus.iREN      = iren;
    bus.iaddr     = iaddr;
    bus.dREN      = dren;
    bus.dWEN      = dwen;
    bus.daddr     = daddr;
    bus.dstore    = dstore;
    bus.ram_ready = rdy;
    bus.ram_load  = load;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[15];
  out_t o;
  int   tout_at;
  logic saw_ihit;
  logic [1:0] hits;

  initial begin
    // One vector per clock cycle; expectations describe outputs within that cycle.
    //            iren iaddr      dren  dwen  daddr      dstore        rdy   load
    vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h3C01_0001, Z};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h3C01_0001,
                 '{1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h3C01_0001, 32'h0, 1'b0}};
    vecs[2]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, Z};
    vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, Z};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0,
                 '{1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0,
                 '{1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0}};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0, Z};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0,
                 '{1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0,
                 '{1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}};
    vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h200, 32'h0,        1'b1, 32'hAAAA, Z};
    vecs[10] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 32'h11, Z};
    vecs[11] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 32'h11,
                 '{1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0}};
    vecs[12] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 32'h11, Z};
    vecs[13] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0,        1'b1, 32'h11,
                 '{1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 32'h0, 32'h11, 1'b0}};
    vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, Z};

    // Requests live during reset must not reach the outputs.
    drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678);
    repeat (2) @(posedge CLK);
    #1;
    check_out("reset_outputs", sample(), Z);

    drive(vecs[0].iren, vecs[0].iaddr, vecs[0].dren, vecs[0].dwen,
          vecs[0].daddr, vecs[0].dstore, vecs[0].rdy, vecs[0].load);
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dstore, vecs[i].rdy, vecs[i].load);
      @(negedge CLK);
      check_out($sformatf("vec%0d", i), sample(), vecs[i].exp);
      next_cycle();
    end

    // Both requesters saturating after reset: D, I, D, I with an IDLE between.
    RST = 1'b1;
    drive(1'b1, 32'h48, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h77);
    next_cycle();
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      hits = {bus.ihit, bus.dhit};
      if (k % 4 == 1)      check_val($sformatf("rr_cycle%0d", k), {30'd0, hits}, 32'd1);
      else if (k % 4 == 3) check_val($sformatf("rr_cycle%0d", k), {30'd0, hits}, 32'd2);
      else                 check_val($sformatf("rr_cycle%0d", k), {30'd0, hits}, 32'd0);
      next_cycle();
    end

    // Asynchronous reset in the middle of a fetch.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    o = sample();
    check_val("iacc_ren", {31'd0, o.ren}, 32'd1);
    check_val("iacc_addr", o.addr, 32'h80);
    #2;
    RST = 1'b1;
    #1;
    check_out("async_reset_midacc", sample(), Z);
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check_out("post_reset_idle", sample(), Z);
    next_cycle();

    // Stalled fetch: watchdog aborts on the 255th cycle, or waits forever when not built.
    tout_at  = 0;
    saw_ihit = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (bus.ihit) saw_ihit = 1'b1;
      if (bus.timeout_err && tout_at == 0) tout_at = n;
      if (n == 1) check_val("stall_ren", {31'd0, bus.ram_ren}, 32'd1);
      next_cycle();
`ifdef MEM_ARBITER_TIMEOUT_EN
      if (tout_at != 0) break;
`endif
    end
    check_val("stall_no_ihit", {31'd0, saw_ihit}, 32'd0);
`ifdef MEM_ARBITER_TIMEOUT_EN
    check_val("timeout_cycle", tout_at, 32'd255);
    @(negedge CLK);
    check_out("after_timeout_idle", sample(), Z);
    next_cycle();
    @(negedge CLK);
    check_val("refetch_ren", {31'd0, bus.ram_ren}, 32'd1);
`else
    check_val("no_timeout", tout_at, 32'd0);
    @(negedge CLK);
    check_val("still_waiting_ren", {31'd0, bus.ram_ren}, 32'd1);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
